// File: rtl/block_stream_gen.sv
// block_stream_gen: command-driven generator of an ASCII stream of nested
// "begin"/"end" keywords and free characters, one character per cycle.
// Keywords are always framed by spaces so a downstream block-balance checker
// sees clean token boundaries; the emitted nesting depth is tracked and
// illegal OPEN/CLOSE commands are consumed and flagged in a sticky error.
module block_stream_gen #(
    parameter int unsigned DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic               cmd_upper,
    input  logic [7:0]         cmd_char,
    output logic               out_valid,
    output logic [7:0]         out_char,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err
);

    localparam logic [1:0] OP_OPEN  = 2'd0;
    localparam logic [1:0] OP_CLOSE = 2'd1;
    localparam logic [1:0] OP_CHAR  = 2'd2;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StPreSp,
        StKey,
        StPostSp,
        StCh
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               close_q, close_d;    // latched keyword: 1 = "end", 0 = "begin"
    logic               upper_q, upper_d;
    logic [7:0]         char_q, char_d;
    logic               last_sp_q, last_sp_d; // last emitted character was a boundary
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;

    logic               accept;
    logic               handshake;
    logic               open_ok;
    logic               close_ok;
    logic [2:0]         last_idx;
    logic [7:0]         letter;

    // Lowercase keyword letter for the given keyword and letter index.
    function automatic logic [7:0] key_letter(input logic is_close, input logic [2:0] i);
        logic [7:0] c;
        c = 8'h00;
        if (is_close) begin
            case (i)
                3'd0:    c = 8'h65; // e
                3'd1:    c = 8'h6e; // n
                default: c = 8'h64; // d
            endcase
        end else begin
            case (i)
                3'd0:    c = 8'h62; // b
                3'd1:    c = 8'h65; // e
                3'd2:    c = 8'h67; // g
                3'd3:    c = 8'h69; // i
                default: c = 8'h6e; // n
            endcase
        end
        return c;
    endfunction

    assign cmd_ready = (state_q == StIdle);
    assign out_valid = (state_q != StIdle);
    assign accept    = cmd_valid & cmd_ready;
    assign handshake = out_valid & out_ready;
    assign open_ok   = (depth_q != DEPTH_MAX);
    assign close_ok  = (depth_q != DEPTH_ZERO);
    assign last_idx  = close_q ? 3'd2 : 3'd4;
    assign depth     = depth_q;
    assign balanced  = (depth_q == DEPTH_ZERO);
    assign err       = err_q;

    // Keyword letter with optional case folding; only meaningful in StKey.
    always_comb begin
        letter = key_letter(close_q, idx_q);
        if (upper_q) begin
            letter = letter - CASE_OFFSET;
        end
    end

    // Output character decoded purely from registered state and latched command.
    always_comb begin
        out_char = 8'h00;
        case (state_q)
            StPreSp:  out_char = ASCII_SPACE;
            StKey:    out_char = letter;
            StPostSp: out_char = ASCII_SPACE;
            StCh:     out_char = char_q;
            default:  out_char = 8'h00;
        endcase
    end

    // Next-state logic: command accept, token sequencing, depth and error tracking.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        close_d   = close_q;
        upper_d   = upper_q;
        char_d    = char_q;
        last_sp_d = last_sp_q;
        depth_d   = depth_q;
        err_d     = err_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (cmd_op)
                        OP_OPEN: begin
                            if (open_ok) begin
                                depth_d = depth_q + 1'b1;
                                close_d = 1'b0;
                                upper_d = cmd_upper;
                                idx_d   = 3'd0;
                                state_d = last_sp_q ? StKey : StPreSp;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLOSE: begin
                            if (close_ok) begin
                                depth_d = depth_q - 1'b1;
                                close_d = 1'b1;
                                upper_d = cmd_upper;
                                idx_d   = 3'd0;
                                state_d = last_sp_q ? StKey : StPreSp;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CHAR: begin
                            char_d  = cmd_char;
                            state_d = StCh;
                        end
                        default: begin
                            // Reserved op: consumed with no effect.
                        end
                    endcase
                end
            end
            StPreSp: begin
                if (handshake) begin
                    idx_d   = 3'd0;
                    state_d = StKey;
                end
            end
            StKey: begin
                if (handshake) begin
                    if (idx_q == last_idx) begin
                        state_d = StPostSp;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StPostSp: begin
                if (handshake) begin
                    last_sp_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StCh: begin
                if (handshake) begin
                    last_sp_d = (char_q == ASCII_SPACE);
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any token in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            close_q   <= 1'b0;
            upper_q   <= 1'b0;
            char_q    <= 8'h00;
            last_sp_q <= 1'b1;
            depth_q   <= DEPTH_ZERO;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            close_q   <= close_d;
            upper_q   <= upper_d;
            char_q    <= char_d;
            last_sp_q <= last_sp_d;
            depth_q   <= depth_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_block_stream_gen.sv
// Bench for block_stream_gen: directed command sequence with a scoreboard of
// expected characters, on a default-width instance and a DEPTH_W=2 instance.
module tb_block_stream_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd3;
    logic       cmd_upper = 1'b0;
    logic [7:0] cmd_char = 8'h00;
    logic       out_ready = 1'b1;
    logic       sel = 1'b0; // 0: default instance, 1: DEPTH_W=2 instance

    logic       valid_a, valid_b;
    logic       cmd_ready_a, out_valid_a, balanced_a, err_a;
    logic [7:0] out_char_a, depth_a;
    logic       cmd_ready_b, out_valid_b, balanced_b, err_b;
    logic [7:0] out_char_b;
    logic [1:0] depth_b;

    logic       obs_ready, obs_valid, obs_balanced, obs_err;
    logic [7:0] obs_char, obs_depth;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    int         m_depth;
    int         m_max;
    bit         m_last_sp;
    bit         m_err;

    bit         hold_prev = 1'b0;
    logic [7:0] hold_char = 8'h00;

    always #5 clk = ~clk;

    assign valid_a = cmd_valid & ~sel;
    assign valid_b = cmd_valid & sel;

    block_stream_gen u_dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (valid_a),
        .cmd_ready (cmd_ready_a),
        .cmd_op    (cmd_op),
        .cmd_upper (cmd_upper),
        .cmd_char  (cmd_char),
        .out_valid (out_valid_a),
        .out_char  (out_char_a),
        .out_ready (out_ready),
        .depth     (depth_a),
        .balanced  (balanced_a),
        .err       (err_a)
    );

    block_stream_gen #(.DEPTH_W(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (valid_b),
        .cmd_ready (cmd_ready_b),
        .cmd_op    (cmd_op),
        .cmd_upper (cmd_upper),
        .cmd_char  (cmd_char),
        .out_valid (out_valid_b),
        .out_char  (out_char_b),
        .out_ready (out_ready),
        .depth     (depth_b),
        .balanced  (balanced_b),
        .err       (err_b)
    );

    assign obs_ready    = sel ? cmd_ready_b : cmd_ready_a;
    assign obs_valid    = sel ? out_valid_b : out_valid_a;
    assign obs_char     = sel ? out_char_b  : out_char_a;
    assign obs_depth    = sel ? {6'b0, depth_b} : depth_a;
    assign obs_balanced = sel ? balanced_b  : balanced_a;
    assign obs_err      = sel ? err_b       : err_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_key(input bit is_close, input bit up);
        string kw;
        logic [7:0] c;
        kw = is_close ? "end" : "begin";
        for (int i = 0; i < kw.len(); i++) begin
            c = kw[i];
            if (up) c = c - 8'h20;
            exp_q.push_back(c);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_depth   = 0;
        m_last_sp = 1'b1;
        m_err     = 1'b0;
    endtask

    // Wait (bounded) until the generator is idle and every expected char was seen.
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (obs_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", {31'b0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, obs_valid}, 32'd0);
        check("rst_cmd_ready", {31'b0, obs_ready}, 32'd1);
        check("rst_out_char", {24'b0, obs_char}, 32'd0);
        check("rst_depth", {24'b0, obs_depth}, 32'd0);
        check("rst_balanced", {31'b0, obs_balanced}, 32'd1);
        check("rst_err", {31'b0, obs_err}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one command, push its expected characters, and check depth/err after accept.
    task automatic send(input logic [1:0] op, input bit up, input logic [7:0] ch);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_upper = up;
        cmd_char  = ch;
        case (op)
            2'd0, 2'd1: begin
                if ((op == 2'd0 && m_depth == m_max) || (op == 2'd1 && m_depth == 0)) begin
                    m_err = 1'b1;
                end else begin
                    if (!m_last_sp) exp_q.push_back(8'h20);
                    push_key(op == 2'd1, up);
                    exp_q.push_back(8'h20);
                    m_last_sp = 1'b1;
                    m_depth   = (op == 2'd0) ? m_depth + 1 : m_depth - 1;
                end
            end
            2'd2: begin
                exp_q.push_back(ch);
                m_last_sp = (ch == 8'h20);
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Scramble command inputs: the token in flight must use the latched copy.
        cmd_op    = 2'($urandom_range(3));
        cmd_upper = 1'($urandom_range(1));
        cmd_char  = 8'($urandom_range(255));
        check("depth_after_cmd", {24'b0, obs_depth}, 32'(m_depth));
        check("err_after_cmd", {31'b0, obs_err}, {31'b0, m_err});
        check("balanced_after_cmd", {31'b0, obs_balanced}, {31'b0, (m_depth == 0)});
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks hold stability.
    always @(negedge clk) begin
        if (hold_prev) begin
            check("hold_valid", {31'b0, obs_valid}, 32'd1);
            check("hold_char", {24'b0, obs_char}, {24'b0, hold_char});
        end
        if (!reset && obs_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_char", {24'b0, obs_char}, 32'h100);
            end else begin
                check("out_char", {24'b0, obs_char}, {24'b0, exp_q.pop_front()});
            end
        end
        hold_prev = !reset && obs_valid && !out_ready;
        hold_char = obs_char;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        m_max = 255;
        model_reset();

        // OPEN then CLOSE: "begin end " with no leading space.
        do_reset();
        send(2'd0, 1'b0, 8'h00);
        send(2'd1, 1'b0, 8'h00);
        wait_idle();
        check("t1_balanced", {31'b0, obs_balanced}, 32'd1);
        check("t1_err", {31'b0, obs_err}, 32'd0);

        // CHAR 'x' then uppercase OPEN: "x BEGIN ".
        send(2'd2, 1'b0, 8'h78);
        send(2'd0, 1'b1, 8'h00);
        wait_idle();
        check("t2_depth", {24'b0, obs_depth}, 32'd1);
        check("t2_balanced", {31'b0, obs_balanced}, 32'd0);

        // Reserved op is consumed with no output.
        send(2'd3, 1'b0, 8'h41);
        wait_idle();

        // CLOSE at depth 0: nothing emitted, sticky err.
        do_reset();
        send(2'd1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_no_output", {31'b0, obs_valid}, 32'd0);
        end
        send(2'd0, 1'b0, 8'h00);
        send(2'd1, 1'b0, 8'h00);
        wait_idle();
        check("t3_err_sticky", {31'b0, obs_err}, 32'd1);

        // OPEN with out_ready toggling: 6 chars, cmd_ready low throughout.
        do_reset();
        send(2'd0, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 2 == 1);
            @(negedge clk);
            check("t4_cmd_ready_low", {31'b0, obs_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("t4_cmd_ready_back", {31'b0, obs_ready}, 32'd1);
        check("t4_all_chars", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;

        // DEPTH_W=2 instance: fourth OPEN rejected, then back to balanced.
        sel   = 1'b1;
        m_max = 3;
        do_reset();
        for (int i = 0; i < 4; i++) send(2'd0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) send(2'd1, 1'b0, 8'h00);
        wait_idle();
        check("t5_depth", {24'b0, obs_depth}, 32'd0);
        check("t5_balanced", {31'b0, obs_balanced}, 32'd1);
        check("t5_err", {31'b0, obs_err}, 32'd1);
        sel   = 1'b0;
        m_max = 255;

        // Reset during the 'g' of " begin": token aborted, next OPEN starts clean.
        do_reset();
        send(2'd2, 1'b0, 8'h61);
        send(2'd0, 1'b0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (obs_valid && obs_char == 8'h67) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("t6_saw_g", {31'b0, found}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_abort_valid", {31'b0, obs_valid}, 32'd0);
        check("t6_abort_depth", {24'b0, obs_depth}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        send(2'd0, 1'b0, 8'h00);
        wait_idle();
        check("t6_depth", {24'b0, obs_depth}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
